// File: rtl/core_pkg.sv
// Shared core definitions: datapath defaults, load funct3 encodings and
// writeback-select encoding used by the pipeline back end.
package core_pkg;

  localparam int unsigned CORE_XLEN       = 32;
  localparam int unsigned CORE_REG_ADDR_W = 5;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/load_extender.sv
// Extracts the addressed byte/halfword from an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_extender
  import core_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // addr[0] is ignored for halfwords; misaligned halves are not trapped
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      LD_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LD_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
      LD_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
      LD_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
      LD_W:    o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback: load formatting, write-data
// select, register-file write port and load-pending stall request.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = CORE_XLEN,
  parameter int unsigned REG_ADDR_W = CORE_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteM,
  input  logic                  MemReadM,
  input  logic                  JtypeM,
  input  logic [5:0]            ALUSelectM,
  input  logic [REG_ADDR_W-1:0] WriteAddressM,
  input  logic [XLEN-1:0]       ALUOutM,
  input  logic [XLEN-1:0]       DataMemOutM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic                  MemReadyM,
  input  logic                  StallW,
  input  logic                  FlushW,
  output logic                  StallReqW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] WriteAddressW,
  output logic [XLEN-1:0]       WriteDataW
);

  logic                  r_valid;
  logic                  r_regwrite;
  logic                  r_memread;
  logic                  r_jtype;
  logic [2:0]            r_funct3;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_aluout;
  logic [XLEN-1:0]       r_memdata;
  logic [XLEN-1:0]       r_pcplus4;

  logic                  w_pending;
  logic [XLEN-1:0]       w_load_data;
  wb_sel_e               w_wb_sel;
  logic                  w_unused_alusel;

  assign w_unused_alusel = ^ALUSelectM[5:3];

  assign w_pending = MemReadM & ~MemReadyM;
  assign StallReqW = reset & w_pending;

  // Bubbles clear only the control bits; data registers simply hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_jtype    <= 1'b0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_aluout   <= '0;
      r_memdata  <= '0;
      r_pcplus4  <= '0;
    end else if (FlushW) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_jtype    <= 1'b0;
    end else if (!StallW) begin
      if (w_pending) begin
        r_valid    <= 1'b0;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_jtype    <= 1'b0;
      end else begin
        r_valid    <= 1'b1;
        r_regwrite <= RegWriteM;
        r_memread  <= MemReadM;
        r_jtype    <= JtypeM;
        r_funct3   <= ALUSelectM[2:0];
        r_rd       <= WriteAddressM;
        r_aluout   <= ALUOutM;
        r_memdata  <= DataMemOutM;
        r_pcplus4  <= PCPlus4M;
      end
    end
  end

  load_extender #(
    .XLEN(XLEN)
  ) u_load_extender (
    .i_funct3 (r_funct3),
    .i_addr   (r_aluout[1:0]),
    .i_word   (r_memdata),
    .o_data   (w_load_data)
  );

  always_comb begin
    w_wb_sel = WB_ALU;
    if (r_memread)
      w_wb_sel = WB_MEM;
    else if (r_jtype)
      w_wb_sel = WB_PC4;
  end

  always_comb begin
    WriteDataW = r_aluout;
    case (w_wb_sel)
      WB_MEM:  WriteDataW = w_load_data;
      WB_PC4:  WriteDataW = r_pcplus4;
      default: WriteDataW = r_aluout;
    endcase
  end

  assign WriteAddressW = r_rd;
  assign RegWriteW     = r_valid & r_regwrite & (r_rd != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: expected writeback results are
// queued when stimulus is applied and checked one cycle after capture.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        RegWriteM, MemReadM, JtypeM, MemReadyM, StallW, FlushW;
  logic [5:0]  ALUSelectM;
  logic [4:0]  WriteAddressM;
  logic [31:0] ALUOutM, DataMemOutM, PCPlus4M;
  logic        StallReqW, RegWriteW;
  logic [4:0]  WriteAddressW;
  logic [31:0] WriteDataW;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_w9    = 0;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWriteM     (RegWriteM),
    .MemReadM      (MemReadM),
    .JtypeM        (JtypeM),
    .ALUSelectM    (ALUSelectM),
    .WriteAddressM (WriteAddressM),
    .ALUOutM       (ALUOutM),
    .DataMemOutM   (DataMemOutM),
    .PCPlus4M      (PCPlus4M),
    .MemReadyM     (MemReadyM),
    .StallW        (StallW),
    .FlushW        (FlushW),
    .StallReqW     (StallReqW),
    .RegWriteW     (RegWriteW),
    .WriteAddressW (WriteAddressW),
    .WriteDataW    (WriteDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic drive(input logic rw, input logic mr, input logic j,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc, input logic rdy,
                       input logic stall, input logic flush);
    RegWriteM     = rw;
    MemReadM      = mr;
    JtypeM        = j;
    ALUSelectM    = {3'b101, f3};
    WriteAddressM = rd;
    ALUOutM       = alu;
    DataMemOutM   = dm;
    PCPlus4M      = pc;
    MemReadyM     = rdy;
    StallW        = stall;
    FlushW        = flush;
  endtask

  task automatic step(input string tag, input logic rw, input logic [4:0] rd,
                      input logic [31:0] data, input logic chk_data);
    exp_t e;
    e.rw = rw; e.rd = rd; e.data = data; e.chk_data = chk_data; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (RegWriteW === 1'b1 && WriteAddressW === 5'd9) n_w9++;
    chk({e.tag, ".rw"}, {31'd0, RegWriteW}, {31'd0, e.rw});
    if (e.chk_data) begin
      chk({e.tag, ".rd"}, {27'd0, WriteAddressW}, {27'd0, e.rd});
      chk({e.tag, ".data"}, WriteDataW, e.data);
    end
  endtask

  localparam logic [31:0] DM = 32'h80F1_7F22;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 3'd0, 5'd0, '0, '0, '0, 1, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, 3'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom, $urandom, 0, 0);
      if (i == 1) begin MemReadM = 1'b1; MemReadyM = 1'b0; end
      @(posedge clk);
      #1;
      chk("rst.rw",    {31'd0, RegWriteW}, 32'd0);
      chk("rst.rd",    {27'd0, WriteAddressW}, 32'd0);
      chk("rst.data",  WriteDataW, 32'd0);
      chk("rst.stall", {31'd0, StallReqW}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    drive(1, 0, 0, 3'd0, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 32'h100, 1, 0, 0);
    step("add", 1, 5'd5, 32'h0000_1234, 1);

    drive(1, 1, 0, 3'b000, 5'd7, 32'h101, DM, '0, 1, 0, 0);
    step("lb101", 1, 5'd7, 32'h0000_007F, 1);
    drive(1, 1, 0, 3'b000, 5'd7, 32'h103, DM, '0, 1, 0, 0);
    step("lb103", 1, 5'd7, 32'hFFFF_FF80, 1);
    drive(1, 1, 0, 3'b100, 5'd7, 32'h103, DM, '0, 1, 0, 0);
    step("lbu103", 1, 5'd7, 32'h0000_0080, 1);
    drive(1, 1, 0, 3'b001, 5'd7, 32'h102, DM, '0, 1, 0, 0);
    step("lh102", 1, 5'd7, 32'hFFFF_80F1, 1);
    drive(1, 1, 0, 3'b101, 5'd7, 32'h102, DM, '0, 1, 0, 0);
    step("lhu102", 1, 5'd7, 32'h0000_80F1, 1);
    drive(1, 1, 0, 3'b010, 5'd7, 32'h100, DM, '0, 1, 0, 0);
    step("lw", 1, 5'd7, DM, 1);
    drive(1, 1, 0, 3'b001, 5'd7, 32'h100, DM, '0, 1, 0, 0);
    step("lh100", 1, 5'd7, 32'h0000_7F22, 1);

    drive(1, 0, 1, 3'd0, 5'd1, 32'h999, DM, 32'h44, 1, 0, 0);
    step("jal", 1, 5'd1, 32'h0000_0044, 1);
    drive(1, 0, 1, 3'd0, 5'd0, 32'h999, DM, 32'h44, 1, 0, 0);
    step("jal_x0", 0, 5'd0, 32'h0000_0044, 1);

    n_w9 = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'b010, 5'd9, 32'h200, 32'hCAFE_BABE, '0, 0, 0, 0);
      #1;
      chk("slow.stallreq", {31'd0, StallReqW}, 32'd1);
      step("slow.bubble", 0, 5'd0, 32'd0, 0);
    end
    drive(1, 1, 0, 3'b010, 5'd9, 32'h200, 32'hCAFE_BABE, '0, 1, 0, 0);
    #1;
    chk("slow.ready", {31'd0, StallReqW}, 32'd0);
    step("slow.load", 1, 5'd9, 32'hCAFE_BABE, 1);
    drive(0, 0, 0, 3'd0, 5'd9, 32'h0, '0, '0, 1, 0, 0);
    step("slow.after", 0, 5'd0, 32'd0, 0);
    chk("slow.once", n_w9, 32'd1);

    drive(1, 0, 0, 3'd0, 5'd3, 32'h55, '0, '0, 1, 0, 0);
    step("st.add", 1, 5'd3, 32'h55, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 3'd0, 5'd4, 32'h66, '0, 32'h88, 1, 1, 0);
      step("st.hold", 1, 5'd3, 32'h55, 1);
    end
    drive(1, 0, 0, 3'd0, 5'd4, 32'h66, '0, '0, 1, 1, 1);
    step("st.flush", 0, 5'd0, 32'd0, 0);
    drive(1, 0, 0, 3'd0, 5'd4, 32'h66, '0, '0, 1, 0, 0);
    step("st.resume", 1, 5'd4, 32'h66, 1);

    drive(1, 0, 0, 3'd0, 5'd6, 32'h77, '0, '0, 1, 0, 0);
    step("ar.add", 1, 5'd6, 32'h77, 1);
    drive(1, 1, 0, 3'b010, 5'd8, 32'h300, 32'h1234_5678, '0, 0, 0, 0);
    #1;
    chk("ar.pending", {31'd0, StallReqW}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar.rw",    {31'd0, RegWriteW}, 32'd0);
    chk("ar.rd",    {27'd0, WriteAddressW}, 32'd0);
    chk("ar.data",  WriteDataW, 32'd0);
    chk("ar.stall", {31'd0, StallReqW}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar.release", {31'd0, StallReqW}, 32'd1);
    MemReadyM = 1'b1;
    #1;
    chk("ar.ready", {31'd0, StallReqW}, 32'd0);
    step("ar.load", 1, 5'd8, 32'h1234_5678, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
